// File: rtl/sync_rx_pkt_fifo.sv
// ---------------------------------------------------------------------------
// sync_rx_pkt_fifo
//   Single-clock receive FIFO for USB packets. Bytes of the packet being
//   received are written speculatively behind a committed write pointer; the
//   reader only sees bytes up to the committed pointer. A good packet
//   (pktfin) commits, a bad one (pkterr, or pktfin after an overflow) rewinds
//   the write pointer and pulses drop. A new rxact rising edge silently
//   discards any unterminated packet.
//
// Ports
//   CLK     : clock, all state on rising edge
//   RSTn    : asynchronous active-low reset
//   rxact   : receive active, rising edge starts a packet
//   write   : byte write strobe, iData : received byte
//   pktfin  : commit current packet, pkterr : discard current packet
//   read    : reader pop strobe
//   oData   : byte at read pointer (first-word fall-through)
//   rdnum   : registered count of committed, unread bytes
//   full    : no free entry, empty : nothing committed to read
//   drop    : one-cycle pulse when a packet is discarded
// ---------------------------------------------------------------------------
module sync_rx_pkt_fifo #(
    parameter int DSIZE = 8,
    parameter int ASIZE = 9
) (
    input  logic             CLK,
    input  logic             RSTn,
    input  logic             rxact,
    input  logic             write,
    input  logic [DSIZE-1:0] iData,
    input  logic             pktfin,
    input  logic             pkterr,
    input  logic             read,
    output logic [DSIZE-1:0] oData,
    output logic [ASIZE:0]   rdnum,
    output logic             full,
    output logic             empty,
    output logic             drop
);

    localparam int DEPTH = 1 << ASIZE;

    logic [DSIZE-1:0] mem_r [0:DEPTH-1];

    logic [ASIZE:0]   wp_r;
    logic [ASIZE:0]   cwp_r;
    logic [ASIZE:0]   rp_r;
    logic             ovf_r;
    logic [1:0]       rxact_hist_r;
    logic [ASIZE:0]   rdnum_r;
    logic             drop_r;

    logic             full_s;
    logic             empty_s;
    logic             wr_en_s;
    logic [ASIZE:0]   wr_inc_s;
    logic [ASIZE:0]   wp_post_s;
    logic             discard_s;
    logic             commit_s;
    logic             rewind_s;
    logic             mem_we_s;
    logic [ASIZE-1:0] mem_addr_s;

    // Status flags, write qualification and packet control decode
    always_comb begin
        full_s    = (wp_r[ASIZE] != rp_r[ASIZE]) &&
                    (wp_r[ASIZE-1:0] == rp_r[ASIZE-1:0]);
        empty_s   = (rp_r == cwp_r);
        wr_en_s   = write && !full_s;
        wr_inc_s  = {{ASIZE{1'b0}}, wr_en_s};
        wp_post_s = wp_r + wr_inc_s;
        // pkterr wins over pktfin; an overflowed packet can never commit
        discard_s = pkterr || (pktfin && ovf_r);
        commit_s  = pktfin && !pkterr && !ovf_r;
        rewind_s  = (rxact_hist_r == 2'b01);
        mem_we_s  = wr_en_s && !discard_s;
        // A rewind without a commit places the same-cycle byte at the old cwp
        if (rewind_s && !commit_s) begin
            mem_addr_s = cwp_r[ASIZE-1:0];
        end else begin
            mem_addr_s = wp_r[ASIZE-1:0];
        end
    end

    // Packet RAM, intentionally not reset
    always_ff @(posedge CLK) begin
        if (mem_we_s) begin
            mem_r[mem_addr_s] <= iData;
        end
    end

    // Write-side pointers, overflow flag and rxact edge history
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            wp_r         <= {(ASIZE+1){1'b0}};
            cwp_r        <= {(ASIZE+1){1'b0}};
            ovf_r        <= 1'b0;
            rxact_hist_r <= 2'b00;
        end else begin
            rxact_hist_r <= {rxact_hist_r[0], rxact};
            if (discard_s) begin
                wp_r  <= cwp_r;
                ovf_r <= 1'b0;
            end else if (commit_s) begin
                wp_r  <= wp_post_s;
                cwp_r <= wp_post_s;
                ovf_r <= 1'b0;
            end else if (rewind_s) begin
                wp_r  <= cwp_r + wr_inc_s;
                ovf_r <= 1'b0;
            end else begin
                wp_r <= wp_post_s;
                if (write && full_s) begin
                    ovf_r <= 1'b1;
                end else begin
                    ovf_r <= ovf_r;
                end
            end
        end
    end

    // Read pointer, moved only by the reader
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rp_r <= {(ASIZE+1){1'b0}};
        end else if (read && !empty_s) begin
            rp_r <= rp_r + {{ASIZE{1'b0}}, 1'b1};
        end else begin
            rp_r <= rp_r;
        end
    end

    // Registered occupancy count and discard pulse
    always_ff @(posedge CLK or negedge RSTn) begin
        if (!RSTn) begin
            rdnum_r <= {(ASIZE+1){1'b0}};
            drop_r  <= 1'b0;
        end else begin
            rdnum_r <= cwp_r - rp_r;
            drop_r  <= discard_s;
        end
    end

    assign oData = mem_r[rp_r[ASIZE-1:0]];
    assign rdnum = rdnum_r;
    assign full  = full_s;
    assign empty = empty_s;
    assign drop  = drop_r;

endmodule
